gf2m_word_sequencer: RTL



---
 rtl/gf2m_word_sequencer_pkg.sv | 24 ++
 rtl/gf2m_word_sequencer.sv | 110 +++++++++++
 2 files changed

// File: rtl/gf2m_word_sequencer_pkg.sv
// Shared constants, size-derivation helpers and state encoding for the
// GF(2^M) operand word sequencer.
package gf2m_word_sequencer_pkg;

  localparam int W         = 64;
  localparam int MASK_W    = 8;
  localparam int M_DEFAULT = 163;

  // Number of W-bit words needed to hold an M-bit operand.
  function automatic int calc_nw(input int m);
    return (m + W - 1) / W;
  endfunction

  // Padding bits below the operand LSB in the last word (0..W-1).
  function automatic int calc_pad(input int m);
    return calc_nw(m) * W - m;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/gf2m_word_sequencer.sv
// Streams one left-justified GF(2^M) operand MSB-word-first over valid/ready,
// tagging the final word with the padding-bit clear count for the masking stage.
module gf2m_word_sequencer
  import gf2m_word_sequencer_pkg::*;
#(
  parameter int M = M_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [calc_nw(M)*W-1:0]   load_data,
  output logic                      word_valid,
  input  logic                      word_ready,
  output logic [W-1:0]              word_data,
  output logic [MASK_W-1:0]         word_mask,
  output logic                      word_last,
  output logic [MASK_W-1:0]         word_idx
);

  localparam int NW = calc_nw(M);
  localparam int PAD = calc_pad(M);
  localparam int SW = NW * W;
  localparam logic [MASK_W-1:0] LAST_IDX = MASK_W'(NW - 1);
  localparam logic [MASK_W-1:0] PAD_CNT  = MASK_W'(PAD);

  state_t              state_q, state_d;
  logic [SW-1:0]       shift_q, shift_d;
  logic [SW-1:0]       shifted;
  logic [MASK_W-1:0]   cnt_q, cnt_d;
  logic                load_ready_q, load_ready_d;
  logic                word_valid_q, word_valid_d;
  logic                word_last_q, word_last_d;
  logic [MASK_W-1:0]   word_mask_q, word_mask_d;

  assign shifted = shift_q << W;

  // NOTE: every variable gets its hold value first so no path through the
  // case leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    load_ready_d = load_ready_q;
    word_valid_d = word_valid_q;
    word_last_d  = word_last_q;
    word_mask_d  = word_mask_q;

    unique case (state_q)
      IDLE: begin
        load_ready_d = 1'b1;
        if (load_valid && load_ready_q) begin
          state_d      = SEND;
          shift_d      = load_data;
          cnt_d        = '0;
          load_ready_d = 1'b0;
          word_valid_d = 1'b1;
          word_last_d  = (cnt_d == LAST_IDX);
          word_mask_d  = word_last_d ? PAD_CNT : '0;
        end
      end
      SEND: begin
        if (word_valid_q && word_ready) begin
          if (word_last_q) begin
            state_d      = IDLE;
            word_valid_d = 1'b0;
            word_last_d  = 1'b0;
            word_mask_d  = '0;
            load_ready_d = 1'b1;
          end else begin
            shift_d     = shifted;
            cnt_d       = cnt_q + 8'd1;
            word_last_d = (cnt_d == LAST_IDX);
            word_mask_d = word_last_d ? PAD_CNT : '0;
          end
        end
      end
    endcase
  end

  // NOTE: the shift register is reset along with the control state so that
  // word_data reads as zero out of reset; it is a single register, not a RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      load_ready_q <= 1'b0;
      word_valid_q <= 1'b0;
      word_last_q  <= 1'b0;
      word_mask_q  <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      load_ready_q <= load_ready_d;
      word_valid_q <= word_valid_d;
      word_last_q  <= word_last_d;
      word_mask_q  <= word_mask_d;
    end
  end

  assign load_ready = load_ready_q;
  assign word_valid = word_valid_q;
  assign word_data  = shift_q[SW-1 -: W];
  assign word_mask  = word_mask_q;
  assign word_last  = word_last_q;
  assign word_idx   = cnt_q;

endmodule
